// File: rtl/console_tx_buffer.sv
// Buffered, rate-paced console write front end: CPU character writes land in a FIFO and are
// drained to the console one write every DrainDiv cycles; a halt request is sent once drained.
module console_tx_buffer #(
  parameter int unsigned Depth    = 16,
  parameter int unsigned DrainDiv = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        gnt_o,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        con_req_o,
  output logic        con_we_o,
  output logic [31:0] con_addr_o,
  output logic [31:0] con_wdata_o
);

  localparam int unsigned AW       = $clog2(Depth);
  localparam int unsigned CntW     = (DrainDiv > 2) ? $clog2(DrainDiv) : 1;
  localparam int unsigned PaceLast = (DrainDiv > 1) ? DrainDiv - 2 : 0;

  typedef enum logic [1:0] {StIdle, StPace, StHaltSend, StDone} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [7:0]        mem_q [Depth];
  logic [AW-1:0]     wptr_q, rptr_q;
  logic [AW:0]       level_q;
  logic              halt_q;
  logic              rvalid_q;
  logic [31:0]       rdata_q;

  logic is_tx, is_ctl, is_stat;
  logic full, empty, push, pop, set_halt, rd;
  logic [7:0]  level8;
  logic [31:0] status;
  logic        unused_bits;

  assign is_tx   = (addr_i[7:0] == 8'h04);
  assign is_ctl  = (addr_i[7:0] == 8'h08);
  assign is_stat = (addr_i[7:0] == 8'h0C);

  // full/empty come from the registered count, so a same-cycle pop cannot unblock a push
  assign full  = (level_q == (AW+1)'(Depth));
  assign empty = (level_q == '0);

  assign gnt_o    = req_i & ~(we_i & is_tx & full & ~halt_q);
  assign push     = req_i & we_i & is_tx & ~full & ~halt_q;
  assign set_halt = req_i & we_i & is_ctl & wdata_i[0];
  assign rd       = req_i & ~we_i;

  assign level8 = 8'(level_q);
  assign status = {16'b0, level8, 5'b0, halt_q, full, empty};

  assign rvalid_o = rvalid_q;
  assign rdata_o  = rdata_q;

  assign unused_bits = ^{addr_i[31:8], wdata_i[31:8]};

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pop         = 1'b0;
    con_req_o   = 1'b0;
    con_we_o    = 1'b0;
    con_addr_o  = 32'h0;
    con_wdata_o = 32'h0;
    unique case (state_q)
      StIdle: begin
        if (!empty) begin
          pop         = 1'b1;
          con_req_o   = 1'b1;
          con_we_o    = 1'b1;
          con_addr_o  = 32'h4;
          con_wdata_o = {24'b0, mem_q[rptr_q]};
          if (DrainDiv > 1) begin
            state_d = StPace;
            cnt_d   = '0;
          end
        end else if (halt_q) begin
          state_d = StHaltSend;
        end
      end
      StPace: begin
        if (cnt_q == CntW'(PaceLast)) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StHaltSend: begin
        con_req_o   = 1'b1;
        con_we_o    = 1'b1;
        con_addr_o  = 32'h8;
        con_wdata_o = 32'h1;
        state_d     = StDone;
      end
      StDone: ;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wptr_q] <= wdata_i[7:0];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      wptr_q   <= '0;
      rptr_q   <= '0;
      level_q  <= '0;
      halt_q   <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q  <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (push) begin
        wptr_q <= wptr_q + 1'b1;
      end
      if (pop) begin
        rptr_q <= rptr_q + 1'b1;
      end
      unique case ({push, pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
      if (set_halt) begin
        halt_q <= 1'b1;
      end
      rvalid_q <= rd;
      rdata_q  <= (rd && is_stat) ? status : 32'h0;
    end
  end

endmodule

// File: tb/tb_console_tx_buffer.sv
// Scoreboard bench for console_tx_buffer: bus tasks queue expected console writes and read data,
// a negedge monitor pops and compares whenever the DUT presents con_req_o or rvalid_o.
module tb_console_tx_buffer;

  localparam int unsigned Depth    = 16;
  localparam int unsigned DrainDiv = 4;

  logic        clk = 1'b0;
  logic        rst_i, req_i, we_i;
  logic [31:0] addr_i, wdata_i;
  logic        gnt_o, rvalid_o, con_req_o, con_we_o;
  logic [31:0] rdata_o, con_addr_o, con_wdata_o;

  console_tx_buffer #(.Depth(Depth), .DrainDiv(DrainDiv)) dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .req_i      (req_i),
    .we_i       (we_i),
    .addr_i     (addr_i),
    .wdata_i    (wdata_i),
    .gnt_o      (gnt_o),
    .rvalid_o   (rvalid_o),
    .rdata_o    (rdata_o),
    .con_req_o  (con_req_o),
    .con_we_o   (con_we_o),
    .con_addr_o (con_addr_o),
    .con_wdata_o(con_wdata_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } con_t;

  con_t        exp_q[$];
  logic [31:0] rd_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          last_req = -100;
  logic        halt_m = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
    end
  endfunction

  // Monitor
  always @(negedge clk) begin
    con_t        e;
    logic [31:0] r;
    if (!rst_i) begin
      if (con_req_o) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL con_unexpected: got addr %h data %h expected no request (cycle %0d)",
                   con_addr_o, con_wdata_o, cyc);
        end else begin
          e = exp_q.pop_front();
          chk("con_addr", con_addr_o, e.addr);
          chk("con_wdata", con_wdata_o, e.data);
          chk("con_we", {31'b0, con_we_o}, 32'h1);
          chk("con_gap_ge_div", {31'b0, (cyc - last_req) >= DrainDiv}, 32'h1);
          last_req = cyc;
        end
      end else begin
        chk("con_idle_zero", con_addr_o | con_wdata_o | {31'b0, con_we_o}, 32'h0);
      end
      if (rvalid_o) begin
        if (rd_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rvalid_unexpected: got rdata %h expected no rvalid (cycle %0d)",
                   rdata_o, cyc);
        end else begin
          r = rd_q.pop_front();
          chk("rdata", rdata_o, r);
        end
      end
    end
  end

  // All bus tasks start and end at posedge+1.
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d, output int stalls);
    con_t e;
    int   n = 0;
    stalls = 0;
    req_i = 1'b1; we_i = 1'b1; addr_i = a; wdata_i = d;
    @(negedge clk);
    while (!gnt_o && n < 200) begin
      n++;
      stalls++;
      @(negedge clk);
    end
    if (!gnt_o) begin
      checks++;
      errors++;
      $display("FAIL write_grant_timeout: got gnt 0 expected 1 (addr %h)", a);
    end else if (a[7:0] == 8'h04 && !halt_m) begin
      e.addr = 32'h4;
      e.data = {24'b0, d[7:0]};
      exp_q.push_back(e);
    end else if (a[7:0] == 8'h08 && d[0] && !halt_m) begin
      halt_m = 1'b1;
      e.addr = 32'h8;
      e.data = 32'h1;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    req_i = 1'b0; we_i = 1'b0; addr_i = '0; wdata_i = '0;
  endtask

  task automatic bus_read(input logic [31:0] a, input logic [31:0] expv);
    req_i = 1'b1; we_i = 1'b0; addr_i = a;
    @(negedge clk);
    chk("read_gnt", {31'b0, gnt_o}, 32'h1);
    rd_q.push_back(expv);
    @(posedge clk);
    #1;
    req_i = 1'b0; addr_i = '0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 1000) begin
      n++;
      @(negedge clk);
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
    end
    idle(8);
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    @(posedge clk);
    #1;
    rst_i = 1'b0;
    exp_q.delete();
    rd_q.delete();
    halt_m   = 1'b0;
    last_req = -100;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int st;
    int total;
    rst_i = 1'b1; req_i = 1'b0; we_i = 1'b0; addr_i = '0; wdata_i = '0;
    repeat (3) @(posedge clk);
    #1;
    rst_i = 1'b0;
    @(negedge clk);
    chk("reset_con_req", {31'b0, con_req_o}, 32'h0);
    chk("reset_rvalid", {31'b0, rvalid_o}, 32'h0);
    chk("reset_rdata", rdata_o, 32'h0);
    chk("reset_gnt_idle", {31'b0, gnt_o}, 32'h0);
    idle(1);
    bus_read(32'h0C, 32'h0000_0001);

    // Single character, one-cycle latency from empty
    bus_write(32'h04, 32'h41, st);
    @(negedge clk);
    chk("first_char_latency", {31'b0, con_req_o}, 32'h1);
    idle(10);

    // Zero SIMCTRL write, unmapped write and read are ignored
    bus_write(32'h08, 32'h0, st);
    bus_write(32'h20, 32'h55, st);
    bus_read(32'h0C, 32'h0000_0001);
    bus_read(32'h10, 32'h0);

    // Burst long enough to overtake the drain rate and fill the FIFO
    total = 0;
    for (int i = 0; i < 24; i++) begin
      bus_write(32'h04, 32'h61 + i, st);
      total += st;
    end
    chk("burst_stalled", {31'b0, total > 0}, 32'h1);
    wait_drain();

    // 5 pushes back-to-back, read next cycle: one already drained, level 4
    for (int i = 0; i < 5; i++) bus_write(32'h04, 32'h30 + i, st);
    bus_read(32'h0C, 32'h0000_0400);
    wait_drain();

    // Reset with characters queued flushes them
    for (int i = 0; i < 8; i++) bus_write(32'h04, 32'h41 + i, st);
    do_reset();
    bus_read(32'h0C, 32'h0000_0001);
    idle(12);

    // Three chars then halt; a later char is granted and dropped
    for (int i = 0; i < 3; i++) bus_write(32'h04, 32'h78 + i, st);
    bus_write(32'h08, 32'h1, st);
    bus_write(32'h04, 32'h5A, st);
    chk("halt_drop_no_stall", st, 0);
    bus_read(32'h0C, 32'h0000_0204);
    wait_drain();
    idle(20);
    bus_read(32'h0C, 32'h0000_0005);
    idle(2);

    // Recovery after reset
    do_reset();
    bus_read(32'h0C, 32'h0000_0001);
    bus_write(32'h04, 32'h7E, st);
    wait_drain();

    chk("exp_q_empty", exp_q.size(), 32'h0);
    chk("rd_q_empty", rd_q.size(), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
